restoring_divider_core: RTL

Self-contained, parametrised unsigned restoring divider. It merges the shift/subtract datapath and its sequencing controller into one block with a start/done handshake. It produces one quotient bit per clock and flags divide-by-zero. The control unit or bus wrapper instantiates it wherever an iterative divide is needed.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_step.sv | 35 +++
 rtl/restoring_divider_core.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_DIVISOR_W  = 7;

    // Ceiling log2 with a floor of one bit, sized for the iteration counter
    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract,
// keep the difference or restore, and emit the resulting quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int DIVISOR_W = DEF_DIVISOR_W
) (
    input  logic [DIVISOR_W:0]   p_i,
    input  logic                 bit_i,
    input  logic [DIVISOR_W-1:0] divisor_i,
    output logic [DIVISOR_W:0]   p_o,
    output logic                 q_o
);

    logic [DIVISOR_W:0]   shifted_s;
    logic [DIVISOR_W+1:0] trial_s;
    logic                 unused_s;

    // The partial remainder is always below the divisor, so its MSB never feeds the shift
    assign unused_s = p_i[DIVISOR_W];

    // Trial subtraction with one guard bit acting as the borrow/sign
    always_comb begin
        shifted_s = {p_i[DIVISOR_W-1:0], bit_i};
        trial_s   = {1'b0, shifted_s} - {2'b00, divisor_i};
        if (trial_s[DIVISOR_W+1] == 1'b0) begin
            p_o = trial_s[DIVISOR_W:0];
            q_o = 1'b1;
        end else begin
            p_o = shifted_s;
            q_o = 1'b0;
        end
    end

endmodule

// File: rtl/restoring_divider_core.sv
// Iterative restoring divider with start/done handshake, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (truncating division).
module restoring_divider_core
    import div_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int CNT_W = clog2(DIVIDEND_W);

    state_e                state_q;
    logic [CNT_W-1:0]      count_q;
    logic [DIVIDEND_W-1:0] dq_q;
    logic [DIVISOR_W-1:0]  dvs_q;
    logic [DIVISOR_W:0]    p_q;
    logic                  zero_q;
    logic                  busy_q;
    logic                  done_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  dbz_q;
    logic [DIVISOR_W:0]    p_d;
    logic                  qbit_d;
    logic [DIVIDEND_W-1:0] dvd_mag_s;
    logic [DIVISOR_W-1:0]  dvs_mag_s;
    logic [DIVIDEND_W-1:0] q_res_s;
    logic [DIVISOR_W-1:0]  r_res_s;

`ifdef SIGNED_DIV_EN
    logic neg_q_q;
    logic neg_r_q;

    // Magnitudes at capture, signs re-applied on the finished result
    always_comb begin
        dvd_mag_s = dividend[DIVIDEND_W-1] ? (~dividend + {{(DIVIDEND_W-1){1'b0}}, 1'b1}) : dividend;
        dvs_mag_s = divisor[DIVISOR_W-1] ? (~divisor + {{(DIVISOR_W-1){1'b0}}, 1'b1}) : divisor;
        q_res_s   = neg_q_q ? (~dq_q + {{(DIVIDEND_W-1){1'b0}}, 1'b1}) : dq_q;
        r_res_s   = neg_r_q ? (~p_q[DIVISOR_W-1:0] + {{(DIVISOR_W-1){1'b0}}, 1'b1})
                            : p_q[DIVISOR_W-1:0];
    end

    // Result sign flags, meaningful only for a non-zero divisor
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            neg_q_q <= dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            neg_r_q <= dividend[DIVIDEND_W-1];
        end else begin
            neg_q_q <= neg_q_q;
            neg_r_q <= neg_r_q;
        end
    end
`else
    // Unsigned build passes operands and results straight through
    always_comb begin
        dvd_mag_s = dividend;
        dvs_mag_s = divisor;
        q_res_s   = dq_q;
        r_res_s   = p_q[DIVISOR_W-1:0];
    end
`endif

    div_step #(
        .DIVISOR_W (DIVISOR_W)
    ) u_step (
        .p_i       (p_q),
        .bit_i     (dq_q[DIVIDEND_W-1]),
        .divisor_i (dvs_q),
        .p_o       (p_d),
        .q_o       (qbit_d)
    );

    // Sequencer, iteration datapath and registered result outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            count_q     <= {CNT_W{1'b0}};
            dq_q        <= {DIVIDEND_W{1'b0}};
            dvs_q       <= {DIVISOR_W{1'b0}};
            p_q         <= {(DIVISOR_W+1){1'b0}};
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= {DIVIDEND_W{1'b0}};
            remainder_q <= {DIVISOR_W{1'b0}};
            dbz_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        if (divisor == {DIVISOR_W{1'b0}}) begin
                            zero_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            zero_q  <= 1'b0;
                            dq_q    <= dvd_mag_s;
                            dvs_q   <= dvs_mag_s;
                            p_q     <= {(DIVISOR_W+1){1'b0}};
                            count_q <= CNT_W'(DIVIDEND_W - 1);
                            busy_q  <= 1'b1;
                            state_q <= RUN;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    p_q  <= p_d;
                    dq_q <= {dq_q[DIVIDEND_W-2:0], qbit_d};
                    if (count_q == {CNT_W{1'b0}}) begin
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end else begin
                        count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                FINISH: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                    if (zero_q) begin
                        quotient_q  <= {DIVIDEND_W{1'b1}};
                        remainder_q <= {DIVISOR_W{1'b0}};
                        dbz_q       <= 1'b1;
                    end else begin
                        quotient_q  <= q_res_s;
                        remainder_q <= r_res_s;
                        dbz_q       <= 1'b0;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
